// File: rtl/eight_bit_serial_subtractor.sv
// Bit-serial 8-bit subtractor: diff = x - y - bin, one bit per cycle, LSB first; optional ovf via SUB_OVERFLOW_EN.
// Latency: 8 edges from start acceptance to the one-cycle done pulse; results hold until the next done.
// Backpressure: none; start is accepted only in IDLE and is otherwise dropped, never queued.
module eight_bit_serial_subtractor (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       bin,
  input  logic       start,
  output logic [7:0] diff,
  output logic       bout,
  output logic       busy,
`ifdef SUB_OVERFLOW_EN
  output logic       ovf,
`endif
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] a_sr, b_sr;
  logic [6:0] d_sr;
  logic       br;
  logic [2:0] cnt;

  logic a, b, d, br_nxt, last;

  assign a      = a_sr[0];
  assign b      = b_sr[0];
  assign d      = a ^ b ^ br;
  assign br_nxt = (~a & b) | (~(a ^ b) & br);
  assign last   = (cnt == 3'd7);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr <= 8'h00;
      b_sr <= 8'h00;
      d_sr <= 7'h00;
      br   <= 1'b0;
      cnt  <= 3'd0;
      diff <= 8'h00;
      bout <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf  <= 1'b0;
`endif
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      if (state == IDLE && start) begin
        a_sr <= x;
        b_sr <= y;
        br   <= bin;
        cnt  <= 3'd0;
      end else if (state == RUN) begin
        a_sr <= {1'b0, a_sr[7:1]};
        b_sr <= {1'b0, b_sr[7:1]};
        d_sr <= {d, d_sr[6:1]};
        br   <= br_nxt;
        cnt  <= cnt + 3'd1;
        // On the last bit a/b are the operand sign bits and d is the result sign bit.
        if (last) begin
          diff <= {d, d_sr};
          bout <= br_nxt;
`ifdef SUB_OVERFLOW_EN
          ovf  <= (a ^ b) & (a ^ d);
`endif
        end
      end
    end
  end

endmodule
